// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin sharing of one combinational ALU between two
//            requesters, with valid/ready request and response handshakes.
// Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic [4:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [N-1:0]     rsp0_result,
  output logic [3:0]       rsp0_flags,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic [4:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [N-1:0]     rsp1_result,
  output logic [3:0]       rsp1_flags,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [4:0]       alu_op,
  input  logic [N-1:0]     alu_final_sum,
  input  logic             alu_cout,
  input  logic             alu_negative_flag,
  input  logic             alu_overflow_flag,
  input  logic             alu_zero_flag,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_rr_ptr;
  logic             r_owner;
  logic [N-1:0]     r_alu_a;
  logic [N-1:0]     r_alu_b;
  logic [4:0]       r_alu_op;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic [N-1:0]     r_rsp0_result;
  logic [N-1:0]     r_rsp1_result;
  logic [3:0]       r_rsp0_flags;
  logic [3:0]       r_rsp1_flags;
  logic [CNT_W-1:0] r_ops_done;

  logic             w_any_valid;
  logic             w_grant;
  logic             w_owner_ready;
  logic             w_accept;
  logic             w_rsp_done;
  logic             w_req0_ready;
  logic             w_req1_ready;
  logic             w_busy;

  // rr_ptr only breaks ties; a lone requester always wins.
  assign w_any_valid   = req0_valid | req1_valid;
  assign w_grant       = (req0_valid & req1_valid) ? r_rr_ptr : req1_valid;
  assign w_owner_ready = r_owner ? rsp1_ready : rsp0_ready;
  assign w_accept      = (r_state == S_IDLE) && w_any_valid;
  assign w_rsp_done    = (r_state == S_RESP) && w_owner_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_valid) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (w_owner_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    w_busy       = 1'b1;
    if (r_state == S_IDLE) begin
      w_busy       = 1'b0;
      w_req0_ready = w_any_valid && !w_grant;
      w_req1_ready = w_any_valid &&  w_grant;
    end
  end

  // Operand, response and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr      <= 1'b0;
      r_owner       <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_rsp0_valid  <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp1_result <= '0;
      r_rsp0_flags  <= '0;
      r_rsp1_flags  <= '0;
      r_ops_done    <= '0;
    end else begin
      if (w_accept) begin
        r_owner  <= w_grant;
        r_alu_a  <= w_grant ? req1_a  : req0_a;
        r_alu_b  <= w_grant ? req1_b  : req0_b;
        r_alu_op <= w_grant ? req1_op : req0_op;
      end
      if (r_state == S_EXEC) begin
        if (r_owner) begin
          r_rsp1_result <= alu_final_sum;
          r_rsp1_flags  <= {alu_cout, alu_negative_flag, alu_overflow_flag, alu_zero_flag};
          r_rsp1_valid  <= 1'b1;
        end else begin
          r_rsp0_result <= alu_final_sum;
          r_rsp0_flags  <= {alu_cout, alu_negative_flag, alu_overflow_flag, alu_zero_flag};
          r_rsp0_valid  <= 1'b1;
        end
      end
      if (w_rsp_done) begin
        if (r_owner) r_rsp1_valid <= 1'b0;
        else         r_rsp0_valid <= 1'b0;
        r_rr_ptr   <= ~r_owner;
        r_ops_done <= r_ops_done + CNT_W'(1);
      end
    end
  end

  assign req0_ready  = w_req0_ready;
  assign req1_ready  = w_req1_ready;
  assign busy        = w_busy;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp0_result = r_rsp0_result;
  assign rsp1_result = r_rsp1_result;
  assign rsp0_flags  = r_rsp0_flags;
  assign rsp1_flags  = r_rsp1_flags;
  assign ops_done    = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Directed, table-driven bench for alu_share_arbiter with an ALU stub.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;

  localparam int N     = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
  logic [4:0] req0_op, req1_op, alu_op;
  logic [3:0] rsp0_flags, rsp1_flags;
  logic [N-1:0] alu_a, alu_b, alu_final_sum;
  logic alu_cout, alu_negative_flag, alu_overflow_flag, alu_zero_flag;
  logic busy;
  logic [CNT_W-1:0] ops_done;

  int tests = 0;
  int fails = 0;
  logic [CNT_W-1:0] exp_ops = '0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_final_sum(alu_final_sum),
    .alu_cout(alu_cout), .alu_negative_flag(alu_negative_flag),
    .alu_overflow_flag(alu_overflow_flag), .alu_zero_flag(alu_zero_flag),
    .busy(busy), .ops_done(ops_done)
  );

  // ALU stub: op 1 = add, op 2 = subtract, anything else = xor
  logic [32:0] alu_t;
  always_comb begin
    alu_t             = {1'b0, alu_a ^ alu_b};
    alu_overflow_flag = 1'b0;
    if (alu_op == 5'b00001) begin
      alu_t             = {1'b0, alu_a} + {1'b0, alu_b};
      alu_overflow_flag = (alu_a[31] == alu_b[31]) && (alu_t[31] != alu_a[31]);
    end else if (alu_op == 5'b00010) begin
      alu_t             = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      alu_overflow_flag = (alu_a[31] != alu_b[31]) && (alu_t[31] != alu_a[31]);
    end
    alu_final_sum     = alu_t[31:0];
    alu_cout          = alu_t[32];
    alu_negative_flag = alu_t[31];
    alu_zero_flag     = (alu_t[31:0] == 32'd0);
  end

  typedef struct {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full transaction on a single requester with rsp_ready held high
  task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input logic [31:0] res, input logic [3:0] flg);
    @(negedge clk);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (sel) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else     begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    #1;
    chk("grant_ready", {30'd0, req1_ready, req0_ready}, sel ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_op", {27'd0, alu_op}, {27'd0, op});
    chk("exec_busy_noready", {29'd0, busy, req1_ready, req0_ready}, 32'd4);
    chk("exec_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, sel ? 32'd2 : 32'd1);
    chk("rsp_result", sel ? rsp1_result : rsp0_result, res);
    chk("rsp_flags", {28'd0, sel ? rsp1_flags : rsp0_flags}, {28'd0, flg});
    @(posedge clk); #1;
    exp_ops = exp_ops + 1'b1;
    chk("done_idle", {29'd0, busy, rsp1_valid, rsp0_valid}, 32'd0);
    chk("ops_done", {28'd0, ops_done}, {28'd0, exp_ops});
  endtask

  initial begin
    logic acc0, acc1, got0, got1;

    vecs[0] = '{1'b0, 32'hFFFFFF9C, 32'hFFFFFFCE, 5'b00001, 32'hFFFFFF6A, 4'b1100};
    vecs[1] = '{1'b1, 32'h7FFFFFFF, 32'h00000001, 5'b00001, 32'h80000000, 4'b0110};
    vecs[2] = '{1'b1, 32'd5,        32'd7,        5'b00010, 32'hFFFFFFFE, 4'b0100};
    vecs[3] = '{1'b0, 32'h80000000, 32'h00000001, 5'b00010, 32'h7FFFFFFF, 4'b1010};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 5'b00001, 32'h00000000, 4'b1001};

    rst = 1'b1;
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;
    {req0_a, req0_b, req1_a, req1_b} = '0;
    req0_op = '0;
    req1_op = '0;
    #1;
    chk("reset_alu", alu_a | alu_b | {27'd0, alu_op}, 32'd0);
    chk("reset_rsp", rsp0_result | rsp1_result | {24'd0, rsp0_flags, rsp1_flags}, 32'd0);
    chk("reset_ctl", {26'd0, busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, 1'b0}, 32'd0);
    chk("reset_ops", {28'd0, ops_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg);

    // Simultaneous requests: last owner was 0, so requester 1 wins the tie
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd20; req0_op = 5'b00010;
    req1_valid = 1'b1; req1_a = 32'd50;  req1_b = 32'd50; req1_op = 5'b00010;
    #1;
    chk("tie_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
    acc1 = 1'b1; acc0 = 1'b0; got0 = 1'b0; got1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (rsp0_valid && rsp1_valid) chk("tie_both_valid", 32'd1, 32'd0);
      if (rsp1_valid && !got1) begin
        got1 = 1'b1;
        chk("tie_rsp1_first", {31'd0, got0}, 32'd0);
        chk("tie_rsp1_result", rsp1_result, 32'h0);
        chk("tie_rsp1_flags", {28'd0, rsp1_flags}, 32'b1001);
      end
      if (rsp0_valid && !got0) begin
        got0 = 1'b1;
        chk("tie_rsp0_result", rsp0_result, 32'h50);
        chk("tie_rsp0_flags", {28'd0, rsp0_flags}, 32'b1000);
      end
    end
    chk("tie_both_served", {30'd0, got1, got0}, 32'd3);
    exp_ops = exp_ops + 2'd2;
    chk("tie_ops_done", {28'd0, ops_done}, {28'd0, exp_ops});

    // Response backpressure on requester 0 while requester 1 waits
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 5'b00001;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd3; req1_op = 5'b00010;
    @(posedge clk); #1;
    chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {29'd0, rsp0_valid, busy, req1_ready}, 32'b110);
      chk("bp_result", {rsp0_result[27:0], rsp0_flags}, {28'd3, 4'b0000});
    end
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    exp_ops = exp_ops + 1'b1;
    chk("bp_released", {30'd0, rsp0_valid, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("bp_req1_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("bp_rsp1", {rsp1_result[27:0], rsp1_flags}, {28'd7, 4'b1000});
    @(posedge clk); #1;
    exp_ops = exp_ops + 1'b1;
    chk("bp_ops_done", {28'd0, ops_done}, {28'd0, exp_ops});

    // Reset asserted during EXEC
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 5'b00001;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_alu", alu_a | alu_b | {27'd0, alu_op}, 32'd0);
    chk("mid_rst_rsp", rsp0_result | rsp1_result | {24'd0, rsp0_flags, rsp1_flags}, 32'd0);
    chk("mid_rst_ctl", {28'd0, busy, rsp0_valid, rsp1_valid, |ops_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_ops = '0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_rst_no_rsp", {29'd0, busy, rsp0_valid, rsp1_valid}, 32'd0);
    end
    run_op(1'b1, 32'd3, 32'd4, 5'b00001, 32'd7, 4'b0000);

    // Fifteen more completions wrap the 4-bit counter back to zero
    for (int i = 1; i < 16; i++)
      run_op(i[0], i, 32'd1, 5'b00001, i + 1, 4'b0000);
    chk("ops_wrap", {28'd0, ops_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational DPA2 ALU instance (operands a/b, 5-bit alu_op, final_sum, cout, negative/overflow/zero flags) between two requesters.
- Round-robin arbitration; valid/ready handshake on both the request and response sides.
- Registers operands into the ALU and captures the result and flags into a response register for the winning requester.
- Sits between the issue logic and the shared ALU.

Parameters:
- N, 32, operand/result width; must match the ALU instance.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  N  requester 0 operand a
- req0_b  input  N  requester 0 operand b
- req0_op  input  5  requester 0 alu_op
- rsp0_valid  output  1  requester 0 result available
- rsp0_ready  input  1  requester 0 consumes result
- rsp0_result  output  N  requester 0 final_sum
- rsp0_flags  output  4  requester 0 flags: {cout, negative, overflow, zero}
- req1_valid, req1_ready, req1_a, req1_b, req1_op, rsp1_valid, rsp1_ready, rsp1_result, rsp1_flags: same as requester 0, for requester 1
- alu_a  output  N  to ALU operand a
- alu_b  output  N  to ALU operand b
- alu_op  output  5  to ALU opcode
- alu_final_sum  input  N  from ALU
- alu_cout  input  1  from ALU
- alu_negative_flag  input  1  from ALU
- alu_overflow_flag  input  1  from ALU
- alu_zero_flag  input  1  from ALU
- busy  output  1  high when state is not IDLE
- ops_done  output  CNT_W  count of completed response handshakes

Behaviour:
- Reset (async, immediate): state IDLE, rr_ptr=0, owner=0.
  - alu_a, alu_b, alu_op = 0.
  - All rsp*_result and rsp*_flags = 0; all rsp*_valid and req*_ready = 0.
  - busy=0, ops_done=0.
- Reset asserted mid-operation discards the in-flight operation; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection:
    - Only req0_valid high: grant 0.
    - Only req1_valid high: grant 1.
    - Both high: grant rr_ptr.
  - req*_ready is combinational: high only for the granted requester, only in IDLE.
  - On grant, at the clock edge: latch that requester's a/b/op into alu_a/alu_b/alu_op, set owner, go to EXEC.
  - No valid: stay in IDLE; ALU registers hold their previous values.
- EXEC (1 cycle):
  - ALU settles from the registered operands.
  - At the edge: capture alu_final_sum into rsp<owner>_result and {alu_cout, alu_negative_flag, alu_overflow_flag, alu_zero_flag} into rsp<owner>_flags.
  - Set rsp<owner>_valid; go to RESP.
- RESP:
  - rsp<owner>_valid stays high and result/flags stay stable until rsp<owner>_ready is high at a clock edge.
  - On that edge: clear rsp<owner>_valid, set rr_ptr = ~owner, increment ops_done (wraps at 2^CNT_W-1 to 0), go to IDLE.
  - The other requester's rsp signals never change.
- Latency: accept at edge T; rsp_valid high after edge T+1.
  - Minimum spacing between accepts is 3 cycles when rsp_ready is held high.
- No new request is accepted while in EXEC or RESP; req*_ready=0 there.
- A requester deasserting valid before being granted is legal; nothing is latched.
- rsp_ready asserted outside RESP, or by the non-owner, is ignored.
- alu_op is passed through unmodified; the controller does not decode opcodes.
- Result and flags are captured bit-exact from the ALU. The controller does no width extension or masking.

Test Plan (ALU stub in bench: op 5'b00001 gives a+b, op 5'b00010 gives a-b, with 32-bit two's-complement flags):
- Reset → all outputs zero; busy=0; ops_done=0. Then release rst.
- Single add on requester 0 (req0 op=5'b00001, a=-100, b=-50; rsp0_ready=1):
  - req0_ready=1 in the same cycle.
  - rsp0_valid after 2 edges with result 0xFFFFFF6A and flags 4'b1100.
  - ops_done=1.
- Simultaneous requests, with rr_ptr=1 after the first test completes:
  - req0 op=5'b00010, a=100, b=20; req1 op=5'b00010, a=50, b=50.
  - Requester 1 is granted first: rsp1 result 0x00000000, flags 4'b1001.
  - Requester 0 is then served: rsp0 result 0x00000050, flags 4'b1000.
  - rsp1 and rsp0 never both valid.
- Response backpressure: hold rsp0_ready=0 for 5 cycles.
  - rsp0_valid and result stay stable; busy=1; req1_ready stays 0 despite req1_valid=1.
  - After rsp0_ready rises, req1 is accepted in the next IDLE cycle.
- Reset mid-operation: assert rst during EXEC.
  - Outputs return to zero immediately; no rsp_valid pulse.
  - The next request is served normally.
- Counter wrap: force 2^CNT_W completions (or use CNT_W=4 with 16 ops) → ops_done wraps to 0.
